// File: rtl/traffic_timer.sv
// ============================================================================
// Module   : traffic_timer
// Purpose  : Push-button start handshake plus prescaled sequence counter for a
//            downstream traffic controller. A synchronised button edge raises
//            'enable'. The block waits for 'enable_sig' and then counts
//            0..LAST, one step every TICK_DIV clocks, until the controller
//            drops 'enable_sig'.
// Options  : TRAFFIC_TIMER_PAUSE_EN - adds a 'pause' input. While pause is
//            high in RUN, the prescaler and counter hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int LAST     = 51
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       enable_sig,
`ifdef TRAFFIC_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic       enable,
  output logic [5:0] counter,
  output logic       tick,
  output logic       cycle_done
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [5:0]     LAST_V    = 6'(LAST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state_q;
  logic            enable_q;
  logic [5:0]      counter_q;
  logic            tick_q;
  logic            cycle_done_q;
  logic [PW-1:0]   presc_q;

  logic            sync1_q;
  logic            sync2_q;
  logic            sync3_q;
  logic [1:0]      vld_q;
  logic            armed_q;
  logic            start_evt;
  logic            run_hold;

`ifdef TRAFFIC_TIMER_PAUSE_EN
  assign run_hold = pause;
`else
  assign run_hold = 1'b0;
`endif

  // The button is synchronised through two flops, with a third flop for edge
  // detection. Edge detection stays disarmed until the synchronised level has
  // been seen low after reset, so a button already held at reset release
  // cannot start the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= start_btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
      if (vld_q[1] && !sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign start_evt = armed_q & sync2_q & ~sync3_q;

  // Main sequencer: the handshake states, the prescaler/counter and all
  // registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      counter_q    <= 6'd0;
      tick_q       <= 1'b0;
      cycle_done_q <= 1'b0;
      presc_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          counter_q    <= 6'd0;
          presc_q      <= '0;
          tick_q       <= 1'b0;
          cycle_done_q <= 1'b0;
          enable_q     <= 1'b0;
          if (start_evt) begin
            state_q  <= START;
            enable_q <= 1'b1;
          end
        end
        START: begin
          tick_q       <= 1'b0;
          cycle_done_q <= 1'b0;
          counter_q    <= 6'd0;
          presc_q      <= '0;
          if (enable_sig) begin
            state_q  <= RUN;
            enable_q <= 1'b0;
          end
        end
        RUN: begin
          enable_q <= 1'b0;
          if (!enable_sig) begin
            // Loss of acknowledge takes priority over any tick that is due.
            state_q      <= IDLE;
            counter_q    <= 6'd0;
            presc_q      <= '0;
            tick_q       <= 1'b0;
            cycle_done_q <= 1'b0;
          end else if (run_hold) begin
            tick_q       <= 1'b0;
            cycle_done_q <= 1'b0;
          end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
            if (counter_q >= LAST_V) begin
              counter_q    <= 6'd0;
              cycle_done_q <= 1'b1;
            end else begin
              counter_q    <= counter_q + 6'd1;
              cycle_done_q <= 1'b0;
            end
          end else begin
            presc_q      <= presc_q + PW'(1);
            tick_q       <= 1'b0;
            cycle_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          enable_q     <= 1'b0;
          counter_q    <= 6'd0;
          presc_q      <= '0;
          tick_q       <= 1'b0;
          cycle_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign enable     = enable_q;
  assign counter    = counter_q;
  assign tick       = tick_q;
  assign cycle_done = cycle_done_q;

endmodule

`default_nettype wire
